// File: rtl/mm_pkg.sv
// Shared definitions for the 3x3 systolic matrix multiplier: default sizes,
// collector state encoding and the flattened accumulator element offset.
package mm_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ROW    = 3;
    localparam int DEF_COLOUM = 3;

    function automatic int acc_width_of(input int width);
        return 2 * width + 2;
    endfunction

    localparam int DEF_ACC_WIDTH = acc_width_of(DEF_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    // Bit offset of element (r,c) inside a row-major flattened accumulator bus.
    function automatic int elem_offset(input int r, input int c, input int cols, input int acc_width);
        return (r * cols + c) * acc_width;
    endfunction

endpackage

// File: rtl/result_snapshot_buf.sv
// Parallel-load snapshot of all PE accumulators with an index-selected read mux.
module result_snapshot_buf
    import mm_pkg::*;
#(
    parameter int ROW       = DEF_ROW,
    parameter int COLOUM    = DEF_COLOUM,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int IDX_W     = 4
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture,
    input  logic [ROW*COLOUM*ACC_WIDTH-1:0] c_in,
    input  logic [IDX_W-1:0]                sel,
    output logic [ACC_WIDTH-1:0]            data
);

    localparam int N = ROW * COLOUM;

    logic [ACC_WIDTH-1:0] regs [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (capture) begin
            for (int r = 0; r < ROW; r++)
                for (int c = 0; c < COLOUM; c++)
                    regs[r*COLOUM+c] <= c_in[elem_offset(r, c, COLOUM, ACC_WIDTH) +: ACC_WIDTH];
        end
    end

    // Out-of-range selects read as zero rather than aliasing another element.
    always_comb begin
        data = '0;
        for (int i = 0; i < N; i++)
            if (sel == IDX_W'(i)) data = regs[i];
    end

endmodule

// File: rtl/result_collector.sv
// Collects the systolic array results after a settle delay and streams them out
// over valid/ready. Define RESULT_COLUMN_MAJOR_EN for column-major stream order.
module result_collector
    import mm_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ROW           = DEF_ROW,
    parameter int COLOUM        = DEF_COLOUM,
    parameter int ACC_WIDTH     = acc_width_of(WIDTH),
    parameter int SETTLE_CYCLES = 7
)(
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [ROW*COLOUM*ACC_WIDTH-1:0] C_IN,
    output logic [ACC_WIDTH-1:0]            OUT_DATA,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [3:0]                      OUT_INDEX,
    output logic                            OUT_LAST,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int N  = ROW * COLOUM;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [3:0]    LAST_IDX   = 4'(N - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    idx, idx_next;
    logic [3:0]    sel;
    logic          capture;
    logic          xfer;

    assign xfer      = OUT_VALID && OUT_READY;
    assign OUT_INDEX = idx;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        idx_next   = idx;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt + CW'(1);
                if (cnt == SETTLE_END) next_state = CAPTURE;
            end
            CAPTURE: begin
                capture    = 1'b1;
                idx_next   = '0;
                next_state = STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        next_state = DONE_ST;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            DONE_ST: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            idx       <= idx_next;
            OUT_VALID <= (next_state == STREAM);
            OUT_LAST  <= (next_state == STREAM) && (idx_next == LAST_IDX);
            BUSY      <= (next_state != IDLE);
            DONE      <= (next_state == DONE_ST);
        end
    end

`ifdef RESULT_COLUMN_MAJOR_EN
    always_comb sel = 4'((int'(idx) % ROW) * COLOUM + int'(idx) / ROW);
`else
    assign sel = idx;
`endif

    result_snapshot_buf #(
        .ROW       (ROW),
        .COLOUM    (COLOUM),
        .ACC_WIDTH (ACC_WIDTH),
        .IDX_W     (4)
    ) u_snapshot (
        .clk     (CLK),
        .rst     (RST),
        .capture (capture),
        .c_in    (C_IN),
        .sel     (sel),
        .data    (OUT_DATA)
    );

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (3x3, ACC_WIDTH 10, settle 7).
// Expected stream order follows RESULT_COLUMN_MAJOR_EN when that macro is defined.
module tb_result_collector;

    localparam int ROW    = 3;
    localparam int COLOUM = 3;
    localparam int AW     = 10;
    localparam int N      = ROW * COLOUM;
    localparam int SETTLE = 7;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            START = 1'b0;
    logic [N*AW-1:0] C_IN = '0;
    logic [AW-1:0]   OUT_DATA;
    logic            OUT_VALID;
    logic            OUT_READY = 1'b1;
    logic [3:0]      OUT_INDEX;
    logic            OUT_LAST;
    logic            BUSY;
    logic            DONE;

    int checks = 0;
    int errors = 0;
    int exp_data [N];
    logic [N*AW-1:0] c_identity;

    result_collector #(
        .WIDTH(4), .ROW(ROW), .COLOUM(COLOUM), .ACC_WIDTH(AW), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .C_IN(C_IN),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_INDEX(OUT_INDEX), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic start);
        RST = rst;
        START = start;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, OUT_VALID, 0);
        checkOutput({tag, "_data"},  OUT_DATA, 0);
        checkOutput({tag, "_index"}, OUT_INDEX, 0);
        checkOutput({tag, "_last"},  OUT_LAST, 0);
        checkOutput({tag, "_busy"},  BUSY, 0);
        checkOutput({tag, "_done"},  DONE, 0);
    endtask

    // Cycle 0 is the one where START is sampled; first valid is expected in cycle SETTLE+2.
    task automatic startRun(input bit spurious, output int lat);
        applyStimulus(1'b0, 1'b1);
        lat = 1;
        checkOutput("busy_after_start", BUSY, 1);
        while (!OUT_VALID && lat < 50) begin
            START = spurious && (lat == 3);
            @(posedge CLK);
            #1;
            lat++;
        end
        START = 1'b0;
    endtask

    task automatic collectStream(input int stall_from, input int stall_to, input int last_stalls,
                                 input bit spurious, input bit corrupt, input int abort_after);
        int s;
        int xfers;
        int last_left;
        s = 0;
        xfers = 0;
        last_left = last_stalls;
        if (corrupt) C_IN = '1;
        while (xfers < N && s < 100) begin
            START = spurious && (s == 2);
            OUT_READY = !(s >= stall_from && s <= stall_to);
            if (xfers == N - 1 && last_left > 0) begin
                OUT_READY = 1'b0;
                last_left--;
            end
            checkOutput("stream_valid", OUT_VALID, 1);
            checkOutput("stream_done_early", DONE, 0);
            checkOutput("stream_data", OUT_DATA, exp_data[xfers]);
            checkOutput("stream_index", OUT_INDEX, xfers);
            checkOutput("stream_last", OUT_LAST, (xfers == N - 1));
            if (OUT_READY) xfers++;
            @(posedge CLK);
            #1;
            s++;
            if (abort_after > 0 && xfers == abort_after) begin
                START = 1'b0;
                OUT_READY = 1'b1;
                return;
            end
        end
        START = 1'b0;
        OUT_READY = 1'b1;
        checkOutput("xfer_count", xfers, N);
        checkOutput("done_pulse", DONE, 1);
        checkOutput("done_valid_low", OUT_VALID, 0);
        checkOutput("done_busy", BUSY, 1);
    endtask

    task automatic idleAfterDone();
        @(posedge CLK);
        #1;
        checkOutput("post_done", DONE, 0);
        checkOutput("post_busy", BUSY, 0);
        checkOutput("post_valid", OUT_VALID, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COLOUM; c++)
                c_identity[(r*COLOUM+c)*AW +: AW] = AW'(r * COLOUM + c + 1);
        for (int k = 0; k < N; k++) begin
`ifdef RESULT_COLUMN_MAJOR_EN
            exp_data[k] = (k % ROW) * COLOUM + (k / ROW) + 1;
`else
            exp_data[k] = k + 1;
`endif
        end

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        RST = 1'b0;
        checkIdleOutputs("reset");

        $display("[TB] identity stream");
        C_IN = c_identity;
        startRun(1'b0, lat);
        checkOutput("first_valid_latency", lat, SETTLE + 2);
        collectStream(-1, -2, 0, 1'b0, 1'b0, 0);
        idleAfterDone();

        $display("[TB] backpressure");
        startRun(1'b0, lat);
        checkOutput("bp_latency", lat, SETTLE + 2);
        collectStream(1, 3, 3, 1'b0, 1'b0, 0);
        idleAfterDone();

        $display("[TB] snapshot isolation");
        startRun(1'b0, lat);
        collectStream(-1, -2, 0, 1'b0, 1'b1, 0);
        C_IN = c_identity;
        idleAfterDone();

        $display("[TB] reset mid-stream");
        startRun(1'b0, lat);
        collectStream(-1, -2, 0, 1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0);
        RST = 1'b0;
        checkIdleOutputs("midreset");
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("midreset_no_done", DONE, 0);
            checkOutput("midreset_idle", BUSY, 0);
        end
        startRun(1'b0, lat);
        checkOutput("replay_latency", lat, SETTLE + 2);
        collectStream(-1, -2, 0, 1'b0, 1'b0, 0);
        idleAfterDone();

        $display("[TB] spurious start");
        startRun(1'b1, lat);
        checkOutput("spurious_latency", lat, SETTLE + 2);
        collectStream(-1, -2, 0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("start_in_done_ignored", BUSY, 0);
        checkOutput("start_in_done_done", DONE, 0);
        startRun(1'b0, lat);
        checkOutput("restart_latency", lat, SETTLE + 2);
        collectStream(-1, -2, 0, 1'b0, 1'b0, 0);
        idleAfterDone();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
